// File: rtl/gated_click_counter_pkg.sv
// Shared types and constants for the gated click counter.
package gated_click_counter_pkg;

   // Default width of every counter and record field
   localparam int CNT_W_DEF = 32;

   // Control states: waiting for enable, waiting for the first sync edge, integrating
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_INTEG = 2'd2
   } state_e;

   // Time-of-flight value reported when a window saw no gated click
   localparam logic [CNT_W_DEF-1:0] TOF_NONE = '1;

endpackage

// File: rtl/gated_click_counter_rise_edge_det.sv
// Rising-edge detector: one registered history bit, edge reported in the
// same cycle as the sample that is high after a low.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   // Next history value is simply the current sample
   always_comb begin
      prev_d = d;
   end

   // History register
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = d & ~prev_q;

endmodule

// File: rtl/gated_click_counter.sv
// Gated click counter: integrates detector clicks qualified by a detection
// gate over n_periods sync periods and emits one record per window through
// a valid/ready handshake.
module gated_click_counter
   import gated_click_counter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] n_periods,
   input  logic             sync_in,
   input  logic             det_gate,
   input  logic             click,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [CNT_W-1:0] rec_clicks,
   output logic [CNT_W-1:0] rec_first_tof,
   output logic [CNT_W-1:0] rec_period,
   output logic             rec_overrun,
   output logic             busy
);

   // All-ones at this instance's width, derived from the shared "no click" value
   localparam logic [CNT_W-1:0] TOF_NONE_W = {CNT_W{TOF_NONE[0]}};
   localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == TOF_NONE_W) ? v : v + ONE;
   endfunction

   logic sync_edge;
   logic click_edge;
   logic gated_click;

   rise_edge_det u_sync_det (
      .clk  (clk),
      .rst  (rst),
      .d    (sync_in),
      .rise (sync_edge)
   );

   rise_edge_det u_click_det (
      .clk  (clk),
      .rst  (rst),
      .d    (click),
      .rise (click_edge)
   );

   assign gated_click = click_edge & det_gate;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tof_cnt_q, tof_cnt_d;
   logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
   logic [CNT_W-1:0] clicks_q, clicks_d;
   logic             first_seen_q, first_seen_d;
   logic [CNT_W-1:0] first_tof_q, first_tof_d;
   logic [CNT_W-1:0] nper_q, nper_d;
   logic             rec_valid_q, rec_valid_d;
   logic [CNT_W-1:0] rec_clicks_q, rec_clicks_d;
   logic [CNT_W-1:0] rec_first_tof_q, rec_first_tof_d;
   logic [CNT_W-1:0] rec_period_q, rec_period_d;
   logic             rec_overrun_q, rec_overrun_d;
   logic             ovr_pend_q, ovr_pend_d;

   logic [CNT_W-1:0] cur_tof;
   logic [CNT_W-1:0] edge_period;
   logic             arm_start;
   logic             in_integ;
   logic             term;
   logic             win_start;
   logic             accept;

   // Window events: tof of the current cycle, measured period, window start/end
   always_comb begin
      cur_tof     = sync_edge ? '0 : sat_inc(tof_cnt_q);
      edge_period = sat_inc(tof_cnt_q);
      arm_start   = (state_q == ST_ARM) && enable && sync_edge;
      in_integ    = (state_q == ST_INTEG) && enable;
      term        = in_integ && sync_edge && ((sync_cnt_q + ONE) == nper_q);
      win_start   = arm_start || term;
      accept      = rec_valid_q && rec_ready;
   end

   // Next-state logic; dropping enable aborts from any active state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (enable && (n_periods != '0)) state_d = ST_ARM;
         ST_ARM:   if (!enable) state_d = ST_IDLE;
                   else if (sync_edge) state_d = ST_INTEG;
         ST_INTEG: if (!enable) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   // Window counters; a click on the starting sync edge belongs to the new window
   always_comb begin
      tof_cnt_d    = tof_cnt_q;
      sync_cnt_d   = sync_cnt_q;
      clicks_d     = clicks_q;
      first_seen_d = first_seen_q;
      first_tof_d  = first_tof_q;
      nper_d       = nper_q;
      if ((state_q == ST_IDLE) && enable && (n_periods != '0)) begin
         nper_d = n_periods;
      end
      if (win_start) begin
         tof_cnt_d    = '0;
         sync_cnt_d   = '0;
         clicks_d     = gated_click ? ONE : '0;
         first_seen_d = gated_click;
         first_tof_d  = '0;
         // A zero request would never terminate; keep the previous length then
         if (n_periods != '0) nper_d = n_periods;
      end else if (in_integ) begin
         tof_cnt_d = cur_tof;
         if (sync_edge) sync_cnt_d = sync_cnt_q + ONE;
         if (gated_click) begin
            clicks_d = sat_inc(clicks_q);
            if (!first_seen_q) begin
               first_seen_d = 1'b1;
               first_tof_d  = cur_tof;
            end
         end
      end
   end

   // Record slot: load on window end if free (or freed this cycle), else drop and flag
   always_comb begin
      rec_valid_d     = rec_valid_q;
      rec_clicks_d    = rec_clicks_q;
      rec_first_tof_d = rec_first_tof_q;
      rec_period_d    = rec_period_q;
      rec_overrun_d   = rec_overrun_q;
      ovr_pend_d      = ovr_pend_q;
      if (term) begin
         if (!rec_valid_q || accept) begin
            rec_valid_d     = 1'b1;
            rec_clicks_d    = clicks_q;
            rec_first_tof_d = first_seen_q ? first_tof_q : TOF_NONE_W;
            rec_period_d    = edge_period;
            rec_overrun_d   = ovr_pend_q;
            ovr_pend_d      = 1'b0;
         end else begin
            ovr_pend_d = 1'b1;
         end
      end else if (accept) begin
         rec_valid_d = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         tof_cnt_q       <= '0;
         sync_cnt_q      <= '0;
         clicks_q        <= '0;
         first_seen_q    <= 1'b0;
         first_tof_q     <= '0;
         nper_q          <= '0;
         rec_valid_q     <= 1'b0;
         rec_clicks_q    <= '0;
         rec_first_tof_q <= TOF_NONE_W;
         rec_period_q    <= '0;
         rec_overrun_q   <= 1'b0;
         ovr_pend_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         tof_cnt_q       <= tof_cnt_d;
         sync_cnt_q      <= sync_cnt_d;
         clicks_q        <= clicks_d;
         first_seen_q    <= first_seen_d;
         first_tof_q     <= first_tof_d;
         nper_q          <= nper_d;
         rec_valid_q     <= rec_valid_d;
         rec_clicks_q    <= rec_clicks_d;
         rec_first_tof_q <= rec_first_tof_d;
         rec_period_q    <= rec_period_d;
         rec_overrun_q   <= rec_overrun_d;
         ovr_pend_q      <= ovr_pend_d;
      end
   end

   assign rec_valid     = rec_valid_q;
   assign rec_clicks    = rec_clicks_q;
   assign rec_first_tof = rec_first_tof_q;
   assign rec_period    = rec_period_q;
   assign rec_overrun   = rec_overrun_q;

endmodule

// File: doc/gated_click_counter.md
GATED_CLICK_COUNTER -- requirements
Module: gated_click_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all counters and record fields.
REQ-002 SHALL have port clk  input  1: single clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1: arm/run integration; 0 aborts.
REQ-005 SHALL have port n_periods  input  CNT_W: sync periods per integration window.
REQ-006 SHALL have port sync_in  input  1: sync from the sync/pulse/det generator or external source, clk-synchronous.
REQ-007 SHALL have port det_gate  input  1: detection gate, clk-synchronous, level-qualified.
REQ-008 SHALL have port click  input  1: detector click, clk-synchronous; rising edge = event.
REQ-009 SHALL have port rec_valid  output  1: record available.
REQ-010 SHALL have port rec_ready  input  1: consumer accepts record.
REQ-011 SHALL have port rec_clicks  output  CNT_W: gated clicks in window.
REQ-012 SHALL have port rec_first_tof  output  CNT_W: cycles from sync edge to first gated click.
REQ-013 SHALL have port rec_period  output  CNT_W: cycles between last two sync edges of window.
REQ-014 SHALL have port rec_overrun  output  1: at least one record dropped since last accepted record.
REQ-015 SHALL have port busy  output  1: state is not IDLE.

Function
REQ-016 Edge = current sample 1 and previous-cycle sample 0, evaluated in the same cycle as the current sample.
REQ-017 FSM states: IDLE, ARM, INTEG.
REQ-018 IDLE->ARM when enable=1 and n_periods!=0; n_periods=0 keeps IDLE.
REQ-019 ARM->INTEG on sync edge: tof_cnt=0, sync_cnt=0, clicks=0, first-click flag clear, n_periods latched.
REQ-020 INTEG: tof_cnt increments each cycle, saturates at all-ones; reset to 0 in every sync-edge cycle.
REQ-021 Gated click = click edge with det_gate=1 in same cycle; clicks increments, saturates at all-ones.
REQ-022 First gated click in window latches tof = tof_cnt value (0 when coincident with sync edge); no gated click -> rec_first_tof all-ones.
REQ-023 Each sync edge in INTEG: sync_cnt+1; period register = tof_cnt+1 (cycles since previous edge).
REQ-024 Sync edge making sync_cnt reach latched n_periods ends window; same edge starts next window (counters cleared, n_periods relatched), no lost cycle.
REQ-025 Click edge coincident with terminating sync edge counts in the new window with tof 0.
REQ-026 Record loads on clock edge after terminating sync-edge cycle (rec_valid latency 1).
REQ-027 Record transfers when rec_valid and rec_ready; rec_valid drops next cycle unless new record loads same edge.
REQ-028 Record fields held stable while rec_valid=1 and rec_ready=0.
REQ-029 Window ending while record pending unaccepted: new record discarded, overrun sticky set; reported in next loaded record's rec_overrun, then cleared.
REQ-030 Accept and new load in same cycle: new record loads, no overrun.
REQ-031 enable=0 in ARM or INTEG -> IDLE next cycle; partial window discarded; pending record retained.

Reset
REQ-032 rst=1: state IDLE, all counters 0, rec_valid 0, rec_clicks/rec_period 0, rec_first_tof all-ones, rec_overrun 0, busy 0, edge history 0; rst mid-window discards window and pending record.

Structure
REQ-033 Shared package holds CNT_W default, state enum, TOF_NONE (all-ones) constant.
REQ-034 One sub-module rise_edge_det (1-bit registered history, edge output), instantiated for sync_in and click.

Verification
REQ-035 n_periods=1, sync period 100, gate high, click 37 cycles after sync edge -> record clicks=1, first_tof=37, period=100, overrun=0.
REQ-036 n_periods=4, period 50, 3 clicks/period, gate low for one click each period -> clicks=8, period=50.
REQ-037 Gate never high, clicks present -> clicks=0, first_tof=all-ones.
REQ-038 rec_ready=0 for three windows, then 1 -> first record held unchanged, second record after accept has overrun=1, following record overrun=0.
REQ-039 Click coincident with terminating sync edge -> excluded from ending window, counted in next with first_tof=0.
REQ-040 rst or enable=0 mid-window -> IDLE, no record emitted, busy=0 next cycle.
